// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// ---------------------------------------------------------------------------
// Shares one synchronous-read framebuffer memory between the display fetch
// and two game-logic writers.
// - The display fetch always owns its slot.
// - The writers share the remaining cycles round-robin.
// - The fetched pixel is registered for the colour stage, together with a
//   pixel-valid flag and frame-level blanking status.
//
// Ports
//   clk, reset            system clock; synchronous active-low reset
//   pix_tick              one-cycle pixel strobe (>= 3 clk apart)
//   hCount, vCount        timing-generator counters
//   wr_req[1:0]           writer requests
//   wr_addr0/1, wr_data0/1  writer address and data
//   wr_gnt[1:0]           same-cycle write-accepted pulse
//   mem_addr, mem_we, mem_wdata  combinational memory port
//   mem_rdata             memory read data, valid one cycle after the address
//   pixel_out, pixel_valid  registered pixel and its valid flag
//   in_vblank             registered frame state (1 while blanking)
//   frame_done            one-cycle pulse at the start of vertical blanking
//
// Optional feature
//   VGA_FB_BLANK_WRITE_EN : when defined, writers are only served during
//                           vertical blanking (tear-free updates).
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_W        = 160,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_tick,
  input  logic [9:0]        hCount,
  input  logic [9:0]        vCount,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              pixel_valid,
  output logic              in_vblank,
  output logic              frame_done
);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_VBLANK = 1'b1
  } frame_state_e;

  localparam logic [9:0]        H_FIRST = 10'(H_ACT_START);
  localparam logic [9:0]        H_LAST  = 10'(H_ACT_START + H_ACT - 1);
  localparam logic [9:0]        V_FIRST = 10'(V_ACT_START);
  localparam logic [9:0]        V_LAST  = 10'(V_ACT_START + V_ACT - 1);
  localparam logic [9:0]        V_END   = 10'(V_ACT_START + V_ACT);
  localparam logic [ADDR_W-1:0] FB_W_C  = ADDR_W'(FB_W);

  frame_state_e      state_q;
  logic              rr_q;
  logic              fetch_d_q;
  logic [DATA_W-1:0] pixel_q;
  logic              pixelValid_q;
  logic              inVblank_q;
  logic              frameDone_q;

  logic              hAct;
  logic              vAct;
  logic              fetchSlot;
  logic              eligible;
  logic              writeSlot;
  logic              winner;
  logic [9:0]        rowIdx;
  logic [9:0]        colIdx;
  logic [ADDR_W-1:0] rowBase;
  logic [ADDR_W-1:0] fetchAddr;

  assign hAct      = (hCount >= H_FIRST) && (hCount <= H_LAST);
  assign vAct      = (vCount >= V_FIRST) && (vCount <= V_LAST);
  assign fetchSlot = pix_tick && hAct && vAct;

  assign rowIdx = (vCount - V_FIRST) >> SCALE_SHIFT;
  assign colIdx = (hCount - H_FIRST) >> SCALE_SHIFT;

  // Row base = rowIdx * FB_W built as a sum of shifted copies, one per set bit
  // of the constant width, so only adders are generated (160 = 128 + 32).
  always_comb begin
    rowBase = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W_C[i]) begin
        rowBase = rowBase + (ADDR_W'(rowIdx) << i);
      end
    end
  end

  assign fetchAddr = rowBase + ADDR_W'(colIdx);

`ifdef VGA_FB_BLANK_WRITE_EN
  assign eligible = inVblank_q;
`else
  assign eligible = 1'b1;
`endif

  // A write can only use a cycle the display does not need.
  // With a single requester it wins outright; with two, rr_q picks.
  assign writeSlot = reset && !fetchSlot && eligible && (|wr_req);
  assign winner    = (wr_req == 2'b11) ? rr_q : wr_req[1];

  // Memory port mux: fetch first, then the arbitration winner, else idle at 0.
  always_comb begin
    wr_gnt    = 2'b00;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetchSlot) begin
      mem_addr = fetchAddr;
    end else if (writeSlot) begin
      mem_we = 1'b1;
      if (winner) begin
        wr_gnt    = 2'b10;
        mem_addr  = wr_addr1;
        mem_wdata = wr_data1;
      end else begin
        wr_gnt    = 2'b01;
        mem_addr  = wr_addr0;
        mem_wdata = wr_data0;
      end
    end
  end

  // Arbiter pointer, pixel pipeline and frame state machine.
  // The frame state only moves on pixel ticks, when the counters are settled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_VBLANK;
      inVblank_q   <= 1'b1;
      frameDone_q  <= 1'b0;
      rr_q         <= 1'b0;
      fetch_d_q    <= 1'b0;
      pixel_q      <= '0;
      pixelValid_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      fetch_d_q   <= fetchSlot;
      if (writeSlot) begin
        rr_q <= ~winner;
      end
      // Ticks are >= 3 clocks apart, so a returning fetch never coincides
      // with a tick.
      if (fetch_d_q) begin
        pixel_q      <= mem_rdata;
        pixelValid_q <= 1'b1;
      end else if (pix_tick && !fetchSlot) begin
        pixel_q      <= '0;
        pixelValid_q <= 1'b0;
      end
      if (pix_tick) begin
        case (state_q)
          ST_ACTIVE: begin
            if (vCount == V_END) begin
              state_q     <= ST_VBLANK;
              inVblank_q  <= 1'b1;
              frameDone_q <= 1'b1;
            end
          end
          ST_VBLANK: begin
            if (vCount == V_FIRST) begin
              state_q    <= ST_ACTIVE;
              inVblank_q <= 1'b0;
            end
          end
          default: begin
            state_q    <= ST_VBLANK;
            inVblank_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pixel_out   = pixel_q;
  assign pixel_valid = pixelValid_q;
  assign in_vblank   = inVblank_q;
  assign frame_done  = frameDone_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// ---------------------------------------------------------------------------
// Self-checking bench for vga_fb_arbiter.
// - Directed steps cover reset, fetch addressing, blanking, collisions,
//   round-robin ordering and the frame state.
// - A randomized run follows, checked cycle by cycle against an arithmetic
//   reference model.
// - The memory model answers unwritten locations with a fixed address
//   pattern, so preloaded pixel values are known.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 8;
  localparam int MEM_WORDS   = 1 << ADDR_W;
  localparam int H_ACT_START = 144;
  localparam int V_ACT_START = 35;
  localparam int H_ACT       = 640;
  localparam int V_ACT       = 480;
  localparam int FB_W        = 160;
  localparam int SCALE       = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              pix_tick;
  logic [9:0]        hCount;
  logic [9:0]        vCount;
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [1:0]        wr_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pixel_out;
  logic              pixel_valid;
  logic              in_vblank;
  logic              frame_done;

  logic [DATA_W-1:0] memArr [MEM_WORDS];
  bit                written [MEM_WORDS];

  int testsRun  = 0;
  int failCount = 0;

  // Reference-model state (expected register contents after each edge)
  int          mRr;
  bit          mPrevFetch;
  logic [7:0]  mSaved;
  logic [7:0]  mPix;
  bit          mValid;
  bit          mVblank;
  bit          mFrame;
  logic [1:0]  lastGnt;

  // DUT values sampled mid-cycle by applyStimulus
  logic [1:0]        obsGnt;
  logic [ADDR_W-1:0] obsAddr;
  logic              obsWe;

  int gap;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .pix_tick   (pix_tick),
    .hCount     (hCount),
    .vCount     (vCount),
    .wr_req     (wr_req),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_data0   (wr_data0),
    .wr_data1   (wr_data1),
    .wr_gnt     (wr_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pixel_out  (pixel_out),
    .pixel_valid(pixel_valid),
    .in_vblank  (in_vblank),
    .frame_done (frame_done)
  );

  function automatic logic [7:0] pattern(input int a);
    return 8'(a ^ (a >> 7) ^ 'h5A);
  endfunction

  function automatic logic [7:0] memRead(input int a);
    return written[a] ? memArr[a] : pattern(a);
  endfunction

  // Synchronous-read framebuffer memory
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      memArr[int'(mem_addr)]  <= mem_wdata;
      written[int'(mem_addr)] <= 1'b1;
    end
    mem_rdata <= memRead(int'(mem_addr));
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one clock cycle with the inputs currently driven.
  // - Mid-cycle: checks the combinational port against the model.
  // - After the edge: checks the registered outputs.
  task automatic applyStimulus(input string tag);
    int         h;
    int         v;
    int         fAddr;
    bit         fetch;
    bit         elig;
    logic [1:0] eGnt;
    logic [ADDR_W-1:0] eAddr;
    #1;
    h     = int'(hCount);
    v     = int'(vCount);
    fetch = pix_tick && (h >= H_ACT_START) && (h < H_ACT_START + H_ACT) &&
            (v >= V_ACT_START) && (v < V_ACT_START + V_ACT);
    fAddr = fetch ? ((v - V_ACT_START) / SCALE) * FB_W + (h - H_ACT_START) / SCALE : 0;
`ifdef VGA_FB_BLANK_WRITE_EN
    elig = mVblank;
`else
    elig = 1'b1;
`endif
    eGnt = 2'b00;
    if (reset && !fetch && elig) begin
      if (wr_req == 2'b01)      eGnt = 2'b01;
      else if (wr_req == 2'b10) eGnt = 2'b10;
      else if (wr_req == 2'b11) eGnt = (mRr == 0) ? 2'b01 : 2'b10;
    end
    if (fetch)              eAddr = ADDR_W'(fAddr);
    else if (eGnt == 2'b01) eAddr = wr_addr0;
    else if (eGnt == 2'b10) eAddr = wr_addr1;
    else                    eAddr = '0;
    obsGnt  = wr_gnt;
    obsAddr = mem_addr;
    obsWe   = mem_we;
    checkOutput({tag, "_gnt"}, 32'(wr_gnt), 32'(eGnt));
    checkOutput({tag, "_we"}, 32'(mem_we), 32'(eGnt != 2'b00));
    if (reset) checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(eAddr));
    if (eGnt != 2'b00)
      checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'(eGnt[0] ? wr_data0 : wr_data1));
    lastGnt = eGnt;
    if (!reset) begin
      mRr = 0; mPrevFetch = 0; mSaved = 0; mPix = 0; mValid = 0; mVblank = 1; mFrame = 0;
    end else begin
      mFrame = 0;
      if (mPrevFetch) begin
        mPix = mSaved; mValid = 1;
      end else if (pix_tick && !fetch) begin
        mPix = 0; mValid = 0;
      end
      if (fetch) mSaved = memRead(fAddr);
      mPrevFetch = fetch;
      if (eGnt != 2'b00) mRr = eGnt[0] ? 1 : 0;
      if (pix_tick) begin
        if (!mVblank && v == V_ACT_START + V_ACT) begin
          mVblank = 1; mFrame = 1;
        end else if (mVblank && v == V_ACT_START) begin
          mVblank = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    checkOutput({tag, "_pix"}, 32'(pixel_out), 32'(mPix));
    checkOutput({tag, "_valid"}, 32'(pixel_valid), 32'(mValid));
    checkOutput({tag, "_vblank"}, 32'(in_vblank), 32'(mVblank));
    checkOutput({tag, "_fdone"}, 32'(frame_done), 32'(mFrame));
    @(negedge clk);
  endtask

  task automatic fetchAt(input int h, input int v, input int expA, input string tag);
    hCount = 10'(h);
    vCount = 10'(v);
    applyStimulus({tag, "_pre"});
    pix_tick = 1'b1;
    applyStimulus(tag);
    pix_tick = 1'b0;
    checkOutput({tag, "_fetchaddr"}, 32'(obsAddr), 32'(expA));
    checkOutput({tag, "_fetchwe"}, 32'(obsWe), 32'(0));
    applyStimulus({tag, "_post"});
    checkOutput({tag, "_preload"}, 32'(pixel_out), 32'(pattern(expA)));
    checkOutput({tag, "_pvalid"}, 32'(pixel_valid), 32'(1));
    applyStimulus({tag, "_gap"});
  endtask

  task automatic blankAt(input int h, input int v, input string tag);
    hCount = 10'(h);
    vCount = 10'(v);
    applyStimulus({tag, "_pre"});
    pix_tick = 1'b1;
    applyStimulus(tag);
    pix_tick = 1'b0;
    checkOutput({tag, "_idlewe"}, 32'(obsWe), 32'(0));
    checkOutput({tag, "_idleaddr"}, 32'(obsAddr), 32'(0));
    checkOutput({tag, "_blankpix"}, 32'(pixel_out), 32'(0));
    checkOutput({tag, "_blankvalid"}, 32'(pixel_valid), 32'(0));
    applyStimulus({tag, "_gap"});
  endtask

  // Watchdog: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; pix_tick = 1'b0; hCount = '0; vCount = '0;
    wr_req = 2'b11;
    wr_addr0 = 15'h0100; wr_data0 = 8'h11;
    wr_addr1 = 15'h0200; wr_data1 = 8'h22;
    mRr = 0; mPrevFetch = 0; mSaved = 0; mPix = 0; mValid = 0; mVblank = 1; mFrame = 0;
    lastGnt = 2'b00;
    @(negedge clk);

    // Reset held with both writers requesting
    repeat (3) applyStimulus("reset");
    checkOutput("reset_inblank", 32'(in_vblank), 32'(1));

    // Round-robin right after reset: 0,1,0,1
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus("rr");
      checkOutput("rr_order", 32'(obsGnt), 32'((i % 2 == 0) ? 2'b01 : 2'b10));
      if (lastGnt[0]) begin wr_addr0 = 15'(16'h4000 + i); wr_data0 = 8'(8'h30 + i); end
      if (lastGnt[1]) begin wr_addr1 = 15'(16'h5000 + i); wr_data1 = 8'(8'h40 + i); end
    end

    // Reset mid-operation returns the pointer to writer 0
    applyStimulus("midrr");
    wr_addr0 = 15'h4100; wr_data0 = 8'h77;
    reset = 1'b0;
    applyStimulus("midreset");
    reset = 1'b1;
    applyStimulus("afterreset");
    checkOutput("reset_rr", 32'(obsGnt), 32'(2'b01));
    wr_req = 2'b00;
    applyStimulus("idle");

    // Fetch addressing, blank ticks and frame end
    fetchAt(144, 35, 0, "f0");
    fetchAt(147, 35, 0, "f1");
    blankAt(100, 35, "bh");
    fetchAt(148, 39, 161, "f2");
    blankAt(144, 20, "bv");
    fetchAt(783, 514, 19199, "f3");
    hCount = 10'd100; vCount = 10'd515;
    applyStimulus("frame_pre");
    pix_tick = 1'b1;
    applyStimulus("frame");
    pix_tick = 1'b0;
    checkOutput("frame_pulse", 32'(frame_done), 32'(1));
    checkOutput("frame_vblank", 32'(in_vblank), 32'(1));
    applyStimulus("frame_post");
    checkOutput("frame_once", 32'(frame_done), 32'(0));

    // Collision: request raised during a fetch slot
    hCount = 10'd200; vCount = 10'd100;
    applyStimulus("coll_pre");
    pix_tick = 1'b1; wr_req = 2'b01; wr_addr0 = 15'h2222; wr_data0 = 8'h5C;
    applyStimulus("coll");
    pix_tick = 1'b0;
    checkOutput("coll_nognt", 32'(obsGnt), 32'(0));
    checkOutput("coll_fetchaddr", 32'(obsAddr), 32'(2574));
    applyStimulus("coll_next");
    checkOutput("coll_gnt", 32'(obsGnt), 32'(2'b01));
    checkOutput("coll_we", 32'(obsWe), 32'(1));
    checkOutput("coll_addr", 32'(obsAddr), 32'(15'h2222));
    wr_req = 2'b00;
    applyStimulus("coll_gap");

    // Request made mid-frame: stalls until blanking only with the macro
    hCount = 10'd100; vCount = 10'd35; pix_tick = 1'b1;
    applyStimulus("to_active");
    pix_tick = 1'b0;
    vCount = 10'd100; wr_req = 2'b01; wr_addr0 = 15'h1234; wr_data0 = 8'hC3;
    applyStimulus("mid_req");
`ifdef VGA_FB_BLANK_WRITE_EN
    checkOutput("blank_stall", 32'(obsGnt), 32'(0));
`else
    checkOutput("free_grant", 32'(obsGnt), 32'(2'b01));
`endif
    if (lastGnt[0]) wr_req = 2'b00;
    repeat (2) applyStimulus("mid_wait");
    vCount = 10'd515; pix_tick = 1'b1;
    applyStimulus("to_vblank");
    pix_tick = 1'b0;
    applyStimulus("after_vblank");
`ifdef VGA_FB_BLANK_WRITE_EN
    checkOutput("blank_release", 32'(obsGnt), 32'(2'b01));
`endif
    wr_req = 2'b00;

    // Randomized traffic against the reference model
    gap = 1;
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 149) != 0);
      if (pix_tick) begin
        pix_tick = 1'b0;
        gap = 1;
        if ($urandom_range(0, 3) == 0) hCount = 10'($urandom_range(0, 799));
        else                           hCount = 10'($urandom_range(144, 783));
        case ($urandom_range(0, 5))
          0:       vCount = 10'd515;
          1:       vCount = 10'd35;
          2:       vCount = 10'($urandom_range(0, 524));
          default: vCount = 10'($urandom_range(35, 514));
        endcase
      end else if (gap >= 2 && $urandom_range(0, 2) == 0) begin
        pix_tick = 1'b1;
      end else begin
        gap++;
      end
      if (lastGnt[0] || !wr_req[0]) begin
        wr_req[0] = 1'($urandom_range(0, 1));
        wr_addr0  = 15'($urandom);
        wr_data0  = 8'($urandom);
      end
      if (lastGnt[1] || !wr_req[1]) begin
        wr_req[1] = 1'($urandom_range(0, 1));
        wr_addr1  = 15'($urandom);
        wr_data1  = 8'($urandom);
      end
      applyStimulus("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
